// File: rtl/ext_arbiter.sv
// Purpose: two-requester arbiter that sign- or zero-extends the granted immediate into a one-entry output slot.
// Latency: one cycle from grant (reqN_ready) to out_valid; accepts one request per cycle while the consumer drains.
// Backpressure: both reqN_ready stay low while the slot holds a result and out_ready is low.
// Build option: define EXT_ARBITER_RR_EN for round-robin between simultaneous requests (default: requester 0 wins).
module ext_arbiter #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [IN_WIDTH-1:0]  req0_data,
    input  logic                 req0_signed,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [IN_WIDTH-1:0]  req1_data,
    input  logic                 req1_signed,
    output logic                 req1_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   slot_free;
    logic                   gnt0;
    logic                   gnt1;
    logic                   gnt_any;
    logic [IN_WIDTH-1:0]    sel_data;
    logic                   sel_signed;
    logic                   fill_bit;
    logic [OUT_WIDTH-1:0]   ext_data;
    logic [OUT_WIDTH-1:0]   data_q;
    logic                   id_q;

    // The slot can take a new result when empty, or when the held one leaves this cycle; never during reset.
    always_comb begin
        slot_free = !rst && ((state == EMPTY) || out_ready);
    end

`ifdef EXT_ARBITER_RR_EN
    logic last_gnt;

    // Round-robin grant: on a tie the requester that did not win last time is served.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (slot_free) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // Remember the last winner; reset value makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end
`else
    // Fixed priority grant: requester 0 always wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (slot_free) begin
            gnt0 = req0_valid;
            gnt1 = req1_valid && !req0_valid;
        end
    end
`endif

    assign gnt_any    = gnt0 || gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Select the granted requester's immediate and extend it to the output width.
    always_comb begin
        sel_data   = gnt1 ? req1_data   : req0_data;
        sel_signed = gnt1 ? req1_signed : req0_signed;
        fill_bit   = sel_signed && sel_data[IN_WIDTH-1];
        ext_data   = {OUT_WIDTH{fill_bit}};
        ext_data[IN_WIDTH-1:0] = sel_data;
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a grant always fills the slot; a drain with no grant empties it.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (gnt_any) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready && !gnt_any) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Result register: loads only on a grant, so it holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            id_q   <= 1'b0;
        end else if (gnt_any) begin
            data_q <= ext_data;
            id_q   <= gnt1;
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_ext_arbiter.sv
module tb_ext_arbiter;

`ifdef EXT_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_data = '0;
    logic        req0_signed = 1'b0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_data = '0;
    logic        req1_signed = 1'b0;
    logic        req1_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_id;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    ext_arbiter #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_signed(req0_signed), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_signed(req1_signed), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ext16(input logic [15:0] d, input logic s);
        if (s && d[15]) return {16'hFFFF, d};
        return {16'h0000, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive away from the rising edge, check the combinational
    // ready outputs and out_valid, and queue the expected result of any grant.
    task automatic step(input string name, input logic r,
                        input logic v0, input logic [15:0] d0, input logic s0,
                        input logic v1, input logic [15:0] d1, input logic s1,
                        input logic ordy, input logic e_r0, input logic e_r1, input logic e_ov);
        exp_t e;
        @(negedge clk);
        rst = r;
        req0_valid = v0; req0_data = d0; req0_signed = s0;
        req1_valid = v1; req1_data = d1; req1_signed = s1;
        out_ready = ordy;
        #1;
        chk({name, ".req0_ready"}, {31'b0, req0_ready}, {31'b0, e_r0});
        chk({name, ".req1_ready"}, {31'b0, req1_ready}, {31'b0, e_r1});
        chk({name, ".out_valid"},  {31'b0, out_valid},  {31'b0, e_ov});
        if (r) sb.delete();
        if (e_r0) begin e.id = 1'b0; e.data = ext16(d0, s0); sb.push_back(e); end
        if (e_r1) begin e.id = 1'b1; e.data = ext16(d1, s1); sb.push_back(e); end
    endtask

    // Monitor: every accepted output is compared against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got id=%0d data=%h expected no output", out_id, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_id !== e.id || out_data !== e.data) begin
                        errors++;
                        $display("FAIL output: got id=%0d data=%h expected id=%0d data=%h",
                                 out_id, out_data, e.id, e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic        hold_id;
        logic [31:0] hold_data;

        // Reset with both requesters asserting: no grant may occur.
        step("rst0", 1, 1, 16'h1234, 0, 1, 16'h5678, 0, 1, 0, 0, 0);
        step("rst1", 1, 1, 16'h1234, 0, 1, 16'h5678, 0, 1, 0, 0, 0);
        chk("rst.out_data", out_data, 32'h0);
        chk("rst.out_id", {31'b0, out_id}, 32'h0);

        // Sign extension of a negative value on requester 0.
        step("sext0", 0, 1, 16'h8000, 1, 0, 16'h0000, 0, 1, 1, 0, 0);
        // Zero extension on requester 1 while the first result drains.
        step("zext1", 0, 0, 16'h0000, 0, 1, 16'h8000, 0, 1, 0, 1, 1);
        // Sign extension of a positive value leaves upper bits clear.
        step("sextpos", 0, 0, 16'h0000, 0, 1, 16'h3000, 1, 1, 0, 1, 1);

        // Both requesters continuously valid with the consumer always ready.
        for (int k = 0; k < 4; k++) begin
            step("both", 0, 1, 16'h0011, 0, 1, 16'h8022, 1, 1,
                 RR ? (k % 2 == 0) : 1'b1, RR ? (k % 2 == 1) : 1'b0, 1);
        end
        hold_id   = RR ? 1'b1 : 1'b0;
        hold_data = RR ? 32'hFFFF8022 : 32'h00000011;

        // Consumer stalls for three cycles; data changes on the inputs must be ignored.
        for (int k = 0; k < 3; k++) begin
            step("stall", 0, 1, 16'h7FF0 + 16'(k), 1, 1, 16'h8000 + 16'(k), 1, 0, 0, 0, 1);
            chk("stall.out_data", out_data, hold_data);
            chk("stall.out_id", {31'b0, out_id}, {31'b0, hold_id});
        end
        // Release: held result consumed and a new grant in the same cycle.
        step("release", 0, 1, 16'h0044, 1, 1, 16'h8055, 0, 1, 1, 0, 1);

        // Reset while full and stalled discards the held result.
        step("rstfull", 1, 1, 16'h1111, 0, 1, 16'h2222, 0, 0, 0, 0, 1);
        step("postrst", 0, 1, 16'hABCD, 0, 1, 16'h1111, 0, 0, 1, 0, 0);
        chk("postrst.out_data", out_data, 32'h0);
        chk("postrst.out_id", {31'b0, out_id}, 32'h0);
        step("drain", 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 1);
        step("empty", 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0);

        // Single request with the consumer ready: out_valid for exactly one cycle.
        step("single", 0, 0, 16'h0000, 0, 1, 16'hFFFF, 1, 1, 0, 1, 0);
        step("single_out", 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 1);
        step("single_gone", 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0);
        step("idle", 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0);

        chk("sb_empty", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
